// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants and helpers for the hazard/forwarding controller.
//   REG_IDX_W  register index width (5 bits)
//   NUM_REGS   architectural register count (32)
//   FW_SEL_RF  bypass select value meaning "read the regfile"
//   sel_width  width of a per-source bypass select for a given stage count
package hazard_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned NUM_REGS  = 32;
  localparam int unsigned FW_SEL_RF = 0;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  function automatic int unsigned sel_width(input int unsigned num_fw);
    return $clog2(num_fw + 1);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_fw_src_sel.sv
// fw_src_sel: bypass select for one source operand.
//   rs_i      source register index
//   wb_idx_i  destination index per forwarding stage (stage 0 = youngest)
//   w_en_i    write enable per forwarding stage
//   sel_o     0 = regfile, k = forward from stage k-1
// The youngest matching stage wins; x0 is never forwarded.
module fw_src_sel
  import hazard_pkg::*;
#(
  parameter  int unsigned NUM_FW = 2,
  localparam int unsigned SEL_W  = sel_width(NUM_FW)
) (
  input  logic [REG_IDX_W-1:0]        rs_i,
  input  logic [REG_IDX_W*NUM_FW-1:0] wb_idx_i,
  input  logic [NUM_FW-1:0]           w_en_i,
  output logic [SEL_W-1:0]            sel_o
);

  logic found;

  always_comb begin
    sel_o = SEL_W'(FW_SEL_RF);
    found = 1'b0;
    for (int unsigned j = 0; j < NUM_FW; j++) begin
      if (!found && w_en_i[j] && (rs_i != '0) &&
          (wb_idx_i[REG_IDX_W*j +: REG_IDX_W] == rs_i)) begin
        sel_o = SEL_W'(j + 1);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: bypass selects, load-use bubbles and long-latency scoreboard.
//   i_clk/i_rst_n            clock, synchronous active-low reset
//   i_rs_d/i_rs_vld_d        D-stage source indices and read-valids
//   i_rs_e                   E-stage source indices (bypass lookup)
//   i_wb_idx/i_w_en          per-forwarding-stage destination and write enable
//   i_rd_e/i_is_load_e       E-stage destination and load flag
//   i_lc_issue_d/i_rd_d      D holds a long-latency op writing i_rd_d
//   i_lc_done/i_lc_done_idx  long-latency retirement and its register
//   o_fw_sel                 per-source bypass select
//   o_stall_f/o_stall_d      hold PC/F-D and D
//   o_flush_e                bubble into E
//   o_lc_busy                no long-latency slot free this cycle
//   o_sb_err                 sticky: bogus retirement seen
// Optional (HAZARD_STATS_EN): o_stall_cnt, o_fw_cnt saturating cycle counters.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 2,
  parameter int unsigned NUM_FW       = 2,
  parameter int unsigned LOAD_USE_CYC = 1,
  parameter int unsigned LC_MAX_OUT   = 4
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic [REG_IDX_W*NUM_SRC-1:0]        i_rs_d,
  input  logic [NUM_SRC-1:0]                  i_rs_vld_d,
  input  logic [REG_IDX_W*NUM_SRC-1:0]        i_rs_e,
  input  logic [REG_IDX_W*NUM_FW-1:0]         i_wb_idx,
  input  logic [NUM_FW-1:0]                   i_w_en,
  input  logic [REG_IDX_W-1:0]                i_rd_e,
  input  logic                                i_is_load_e,
  input  logic                                i_lc_issue_d,
  input  logic [REG_IDX_W-1:0]                i_rd_d,
  input  logic                                i_lc_done,
  input  logic [REG_IDX_W-1:0]                i_lc_done_idx,
  output logic [sel_width(NUM_FW)*NUM_SRC-1:0] o_fw_sel,
  output logic                                o_stall_f,
  output logic                                o_stall_d,
  output logic                                o_flush_e,
  output logic                                o_lc_busy,
  output logic                                o_sb_err
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]                         o_stall_cnt,
  output logic [31:0]                         o_fw_cnt
`endif
);

  localparam int unsigned SEL_W = sel_width(NUM_FW);
  localparam int unsigned CNT_W = $clog2(LC_MAX_OUT + 1);

  logic [2:0]          lu_cnt_q, lu_cnt_d;
  logic [NUM_REGS-1:0] sb_q, sb_d, pend, clr_mask;
  logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
  logic                err_q, err_d;
  logic                lu_hit, lu_stall, sb_stall, stall, done_ok, lc_busy, accept;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    fw_src_sel #(.NUM_FW(NUM_FW)) u_sel (
      .rs_i     (i_rs_e[REG_IDX_W*k +: REG_IDX_W]),
      .wb_idx_i (i_wb_idx),
      .w_en_i   (i_w_en),
      .sel_o    (o_fw_sel[SEL_W*k +: SEL_W])
    );
  end

  always_comb begin
    lu_hit = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (i_rs_vld_d[k] && (i_rs_d[REG_IDX_W*k +: REG_IDX_W] == i_rd_e)) lu_hit = 1'b1;
    end
    lu_hit = lu_hit && i_is_load_e && (i_rd_e != '0);
  end

  assign lu_stall = (lu_cnt_q != '0);

  // A valid retirement frees its register and its slot in the same cycle,
  // so dependants and a waiting issue proceed without an extra bubble.
  assign done_ok  = i_lc_done && sb_q[i_lc_done_idx] && (out_cnt_q != '0);
  assign clr_mask = done_ok ? (NUM_REGS'(1) << i_lc_done_idx) : '0;
  assign pend     = sb_q & ~clr_mask;
  assign lc_busy  = (out_cnt_q == CNT_W'(LC_MAX_OUT)) && !done_ok;

  always_comb begin
    sb_stall = i_lc_issue_d && (pend[i_rd_d] || lc_busy);
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (i_rs_vld_d[k] && pend[i_rs_d[REG_IDX_W*k +: REG_IDX_W]]) sb_stall = 1'b1;
    end
  end

  assign stall  = lu_stall || sb_stall;
  assign accept = i_lc_issue_d && !stall;

  always_comb begin
    sb_d = pend;
    if (accept) sb_d[i_rd_d] = 1'b1;
    sb_d[0]   = 1'b0;
    out_cnt_d = out_cnt_q + CNT_W'(accept) - CNT_W'(done_ok);
    lu_cnt_d  = lu_stall ? (lu_cnt_q - 3'd1) : (lu_hit ? 3'(LOAD_USE_CYC) : 3'd0);
    err_d     = err_q || (i_lc_done && !done_ok);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      lu_cnt_q  <= '0;
      sb_q      <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      lu_cnt_q  <= lu_cnt_d;
      sb_q      <= sb_d;
      out_cnt_q <= out_cnt_d;
      err_q     <= err_d;
    end
  end

  assign o_stall_f = stall;
  assign o_stall_d = stall;
  assign o_flush_e = stall;
  assign o_lc_busy = lc_busy;
  assign o_sb_err  = err_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, fw_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
      fw_cnt_q    <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if ((o_fw_sel != '0) && (fw_cnt_q != '1)) fw_cnt_q <= fw_cnt_q + 32'd1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_fw_cnt    = fw_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
module tb_hazard_fwd_unit;

  localparam int NUM_SRC    = 2;
  localparam int NUM_FW     = 2;
  localparam int LUC        = 2;
  localparam int LC_MAX_OUT = 4;
  localparam int SEL_W      = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [5*NUM_SRC-1:0]    rs_d, rs_e;
  logic [NUM_SRC-1:0]      rs_vld_d;
  logic [5*NUM_FW-1:0]     wb_idx;
  logic [NUM_FW-1:0]       w_en;
  logic [4:0]              rd_e, rd_d, lc_done_idx;
  logic                    is_load_e, lc_issue_d, lc_done;
  logic [SEL_W*NUM_SRC-1:0] fw_sel;
  logic                    stall_f, stall_d, flush_e, lc_busy, sb_err;
`ifdef HAZARD_STATS_EN
  logic [31:0]             stall_cnt, fw_cnt;
`endif

  always #5 clk = ~clk;

  hazard_fwd_unit #(
    .NUM_SRC(NUM_SRC), .NUM_FW(NUM_FW), .LOAD_USE_CYC(LUC), .LC_MAX_OUT(LC_MAX_OUT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rs_d(rs_d), .i_rs_vld_d(rs_vld_d), .i_rs_e(rs_e),
    .i_wb_idx(wb_idx), .i_w_en(w_en),
    .i_rd_e(rd_e), .i_is_load_e(is_load_e),
    .i_lc_issue_d(lc_issue_d), .i_rd_d(rd_d),
    .i_lc_done(lc_done), .i_lc_done_idx(lc_done_idx),
    .o_fw_sel(fw_sel), .o_stall_f(stall_f), .o_stall_d(stall_d), .o_flush_e(flush_e),
    .o_lc_busy(lc_busy), .o_sb_err(sb_err)
`ifdef HAZARD_STATS_EN
    , .o_stall_cnt(stall_cnt), .o_fw_cnt(fw_cnt)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: set of pending registers, outstanding ops,
  // remaining bubble cycles, sticky error.
  bit m_pend[32];
  int m_out;
  int m_lu;
  bit m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_out = 0;
    m_lu  = 0;
    m_err = 1'b0;
  endtask

  // Oldest stage first, younger matches overwrite: youngest wins.
  function automatic int ref_sel(input logic [4:0] rs);
    int s = 0;
    for (int j = NUM_FW - 1; j >= 0; j--) begin
      logic [4:0] w;
      w = wb_idx[5*j +: 5];
      if (w_en[j] && rs != 5'd0 && w == rs) s = j + 1;
    end
    return s;
  endfunction

  // One clock: compare all outputs against the model at negedge, then step the model.
  task automatic cyc(input string tag, input int exp_stall = -1,
                     input int exp_busy = -1, input int exp_err = -1);
    bit done_ok, busy, sb, stall, hit, acc;
    bit pn[32];
    logic [4:0] r;
    @(negedge clk);
    done_ok = lc_done && m_pend[lc_done_idx] && (m_out > 0);
    pn = m_pend;
    if (done_ok) pn[lc_done_idx] = 1'b0;
    busy = (m_out - (done_ok ? 1 : 0)) >= LC_MAX_OUT;
    sb = lc_issue_d && (pn[rd_d] || busy);
    hit = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      r = rs_d[5*k +: 5];
      if (rs_vld_d[k] && pn[r]) sb = 1'b1;
      if (rs_vld_d[k] && r == rd_e) hit = 1'b1;
    end
    stall = sb || (m_lu > 0);
    for (int k = 0; k < NUM_SRC; k++) begin
      r = rs_e[5*k +: 5];
      chk({tag, ".sel"}, 32'(fw_sel[SEL_W*k +: SEL_W]), 32'(ref_sel(r)));
    end
    chk({tag, ".stall_f"}, 32'(stall_f), 32'(stall));
    chk({tag, ".stall_d"}, 32'(stall_d), 32'(stall));
    chk({tag, ".flush_e"}, 32'(flush_e), 32'(stall));
    chk({tag, ".busy"}, 32'(lc_busy), 32'(busy));
    chk({tag, ".sb_err"}, 32'(sb_err), 32'(m_err));
    if (exp_stall >= 0) chk({tag, ".stall_fixed"}, 32'(stall_d), 32'(exp_stall));
    if (exp_busy >= 0)  chk({tag, ".busy_fixed"}, 32'(lc_busy), 32'(exp_busy));
    if (exp_err >= 0)   chk({tag, ".err_fixed"}, 32'(sb_err), 32'(exp_err));
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_lu > 0) m_lu = m_lu - 1;
      else if (is_load_e && rd_e != 5'd0 && hit) m_lu = LUC;
      acc = lc_issue_d && !stall;
      m_pend = pn;
      if (acc && rd_d != 5'd0) m_pend[rd_d] = 1'b1;
      m_out = m_out + (acc ? 1 : 0) - (done_ok ? 1 : 0);
      if (lc_done && !done_ok) m_err = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [4:0] rs0, rs1, wb0, wb1;
    logic [1:0] en;
    int         sel0, sel1;
  } fw_vec_t;

  fw_vec_t tbl[7];

  initial begin
    tbl[0] = '{5'd5,  5'd6,  5'd5,  5'd5, 2'b11, 1, 0};
    tbl[1] = '{5'd5,  5'd6,  5'd5,  5'd5, 2'b10, 2, 0};
    tbl[2] = '{5'd0,  5'd6,  5'd0,  5'd0, 2'b11, 0, 0};
    tbl[3] = '{5'd3,  5'd4,  5'd4,  5'd3, 2'b11, 2, 1};
    tbl[4] = '{5'd31, 5'd31, 5'd31, 5'd2, 2'b01, 1, 1};
    tbl[5] = '{5'd8,  5'd8,  5'd9,  5'd8, 2'b00, 0, 0};
    tbl[6] = '{5'd8,  5'd9,  5'd9,  5'd8, 2'b11, 2, 1};

    rst_n = 1'b0; rs_d = '0; rs_vld_d = '0; rs_e = '0; wb_idx = '0; w_en = '0;
    rd_e = '0; is_load_e = 1'b0; lc_issue_d = 1'b0; rd_d = '0;
    lc_done = 1'b0; lc_done_idx = '0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;
    cyc("reset", 0, 0, 0);

    // Forwarding table (combinational, no state change).
    for (int i = 0; i < 7; i++) begin
      rs_e = {tbl[i].rs1, tbl[i].rs0};
      wb_idx = {tbl[i].wb1, tbl[i].wb0};
      w_en = tbl[i].en;
      @(negedge clk);
      chk($sformatf("fw%0d.sel0", i), 32'(fw_sel[SEL_W-1:0]), 32'(tbl[i].sel0));
      chk($sformatf("fw%0d.sel1", i), 32'(fw_sel[2*SEL_W-1:SEL_W]), 32'(tbl[i].sel1));
      @(posedge clk); #1;
    end
    rs_e = '0; wb_idx = '0; w_en = '0;

    // Load-use: bubble lasts exactly LUC cycles after detection.
    is_load_e = 1'b1; rd_e = 5'd7; rs_d = {5'd0, 5'd7}; rs_vld_d = 2'b01;
    cyc("lu_det", 0);
    is_load_e = 1'b0;
    cyc("lu_b1", 1);
    cyc("lu_b2", 1);
    cyc("lu_end", 0);
    rs_d = '0; rs_vld_d = '0; rd_e = '0;

    // RAW/WAW against a pending long-latency result.
    lc_issue_d = 1'b1; rd_d = 5'd9;
    cyc("lc_iss", 0);
    cyc("waw9", 1);
    lc_issue_d = 1'b0; rs_d = {5'd0, 5'd9}; rs_vld_d = 2'b01;
    cyc("raw9_a", 1);
    cyc("raw9_b", 1);
    lc_done = 1'b1; lc_done_idx = 5'd9;
    cyc("raw9_done", 0);
    lc_done = 1'b0;
    cyc("raw9_after", 0);
    rs_d = '0; rs_vld_d = '0;

    // Outstanding limit.
    for (int i = 1; i <= 4; i++) begin
      lc_issue_d = 1'b1; rd_d = 5'(i);
      cyc($sformatf("fill%0d", i), 0, 0);
    end
    rd_d = 5'd5;
    cyc("busy_stall", 1, 1);
    lc_done = 1'b1; lc_done_idx = 5'd1;
    cyc("swap", 0, 0);
    lc_issue_d = 1'b0; lc_done = 1'b0;
    cyc("busy_again", 0, 1);
    for (int i = 2; i <= 5; i++) begin
      lc_done = 1'b1; lc_done_idx = 5'(i);
      cyc($sformatf("drain%0d", i), 0, 0, 0);
    end
    lc_done = 1'b0;

    // Sticky error on bogus retirement, cleared only by reset.
    lc_done = 1'b1; lc_done_idx = 5'd12;
    cyc("bad_done", -1, -1, 0);
    lc_done = 1'b0;
    cyc("err_set", -1, -1, 1);
    cyc("err_hold", -1, -1, 1);
    rst_n = 1'b0;
    cyc("err_in_rst", -1, -1, 1);
    rst_n = 1'b1;
    cyc("err_clr", 0, 0, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      int unsigned pq[$];
      rst_n = ($urandom_range(299) != 0);
      for (int k = 0; k < NUM_SRC; k++) begin
        rs_d[5*k +: 5] = 5'($urandom_range(7));
        rs_e[5*k +: 5] = 5'($urandom_range(7));
      end
      rs_vld_d = NUM_SRC'($urandom);
      for (int j = 0; j < NUM_FW; j++) wb_idx[5*j +: 5] = 5'($urandom_range(7));
      w_en = NUM_FW'($urandom);
      is_load_e = ($urandom_range(3) == 0);
      rd_e = 5'($urandom_range(7));
      lc_issue_d = ($urandom_range(3) == 0);
      rd_d = 5'($urandom_range(7, 1));
      pq = {};
      for (int i = 1; i < 32; i++) if (m_pend[i]) pq.push_back(i);
      lc_done = 1'b0; lc_done_idx = '0;
      if (pq.size() > 0 && $urandom_range(2) == 0) begin
        lc_done = 1'b1;
        lc_done_idx = 5'(pq[$urandom_range(pq.size() - 1)]);
      end else if ($urandom_range(39) == 0) begin
        lc_done = 1'b1;
        lc_done_idx = 5'($urandom_range(15));
      end
      cyc("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
